// File: rtl/issue_rfread_stage.sv
// Issue-queue downstream stage: allocates regfile read ports to selected uops and stages them for the FUs.
// Latency: feedback combinational in the issue cycle; uop valid to the FU one cycle later.
// Backpressure: any occupied slot whose FU is not ready raises o_stall; no grants or reads while stalled.

package issue_rfread_pkg;
    localparam int XLEN        = 32;
    localparam int NUMSRCS_INT = 2;
    localparam int IPR_W       = 6;

    typedef logic [IPR_W-1:0] iprIdx_t;

    typedef struct packed {
        iprIdx_t [NUMSRCS_INT-1:0] iprs_idx;
        iprIdx_t                   iprd_idx;
        logic                      rd_wen;
    } exeInfo_t;
endpackage

module issue_rfread_stage
    import issue_rfread_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int INOUTPORT_NUM = 2,
    parameter int RFREAD_PORTS  = 3,
    parameter int WBPORT_NUM    = 6
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [INOUTPORT_NUM-1:0]                               i_can_issue,
    input  logic [INOUTPORT_NUM-1:0][$clog2(DEPTH)-1:0]            i_issue_idx,
    input  exeInfo_t [INOUTPORT_NUM-1:0]                           i_issue_exeInfo,
    output logic                                                   o_stall,
    output logic [INOUTPORT_NUM-1:0]                               o_issue_finished_vec,
    output logic [INOUTPORT_NUM-1:0]                               o_issue_replay_vec,
    output logic [INOUTPORT_NUM-1:0][$clog2(DEPTH)-1:0]            o_feedback_idx,
    output logic [RFREAD_PORTS-1:0]                                o_rf_rd_en,
    output iprIdx_t [RFREAD_PORTS-1:0]                             o_rf_rd_idx,
    input  logic [RFREAD_PORTS-1:0][XLEN-1:0]                      i_rf_rd_data,
    input  logic [WBPORT_NUM-1:0]                                  i_wb_vld,
    input  iprIdx_t [WBPORT_NUM-1:0]                               i_wb_rdIdx,
    input  logic [WBPORT_NUM-1:0][XLEN-1:0]                        i_wb_data,
    output logic [INOUTPORT_NUM-1:0]                               o_fu_vld,
    output exeInfo_t [INOUTPORT_NUM-1:0]                           o_fu_exeInfo,
    output logic [INOUTPORT_NUM-1:0][NUMSRCS_INT-1:0][XLEN-1:0]    o_fu_srcdata,
    input  logic [INOUTPORT_NUM-1:0]                               i_fu_ready
);

    localparam int PW = (RFREAD_PORTS > 1) ? $clog2(RFREAD_PORTS) : 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_FRESH, ST_HELD} slot_st_t;

    slot_st_t          state_q [INOUTPORT_NUM];
    exeInfo_t          info_q  [INOUTPORT_NUM];
    logic [PW-1:0]     pmap_q  [INOUTPORT_NUM][NUMSRCS_INT];
    logic [XLEN-1:0]   held_q  [INOUTPORT_NUM][NUMSRCS_INT];

    logic [INOUTPORT_NUM-1:0] grant;
    logic [PW-1:0]            pmap_d [INOUTPORT_NUM][NUMSRCS_INT];

    assign o_feedback_idx = i_issue_idx;

    // Slot occupancy and stall: a stall means some staged uop is not leaving this cycle.
    always_comb begin
        for (int s = 0; s < INOUTPORT_NUM; s++) begin
            o_fu_vld[s]     = (state_q[s] != ST_EMPTY);
            o_fu_exeInfo[s] = info_q[s];
        end
        o_stall = |(o_fu_vld & ~i_fu_ready);
    end

    // Read-port allocation: slots in order, a slot is granted only if all its sources fit.
    always_comb begin
        int used;
        int need;
        used                 = 0;
        need                 = 0;
        grant                = '0;
        o_issue_finished_vec = '0;
        o_issue_replay_vec   = '0;
        o_rf_rd_en           = '0;
        o_rf_rd_idx          = '0;
        for (int s = 0; s < INOUTPORT_NUM; s++) begin
            for (int j = 0; j < NUMSRCS_INT; j++) begin
                pmap_d[s][j] = '0;
            end
        end
        for (int s = 0; s < INOUTPORT_NUM; s++) begin
            need = 0;
            for (int j = 0; j < NUMSRCS_INT; j++) begin
                if (i_issue_exeInfo[s].iprs_idx[j] != '0) begin
                    need = need + 1;
                end
            end
            if (i_can_issue[s] && !o_stall) begin
                if (used + need <= RFREAD_PORTS) begin
                    grant[s]                = 1'b1;
                    o_issue_finished_vec[s] = 1'b1;
                    for (int j = 0; j < NUMSRCS_INT; j++) begin
                        if (i_issue_exeInfo[s].iprs_idx[j] != '0) begin
                            o_rf_rd_en[used]  = 1'b1;
                            o_rf_rd_idx[used] = i_issue_exeInfo[s].iprs_idx[j];
                            pmap_d[s][j]      = PW'(used);
                            used              = used + 1;
                        end
                    end
                end else begin
                    // Denied slots consume nothing, so a later smaller slot may still fit.
                    o_issue_replay_vec[s] = 1'b1;
                end
            end
        end
    end

    // Operand resolve: regfile data when fresh, latched data when held; lowest matching bypass wins.
    always_comb begin
        logic [XLEN-1:0] v;
        v = '0;
        for (int s = 0; s < INOUTPORT_NUM; s++) begin
            for (int j = 0; j < NUMSRCS_INT; j++) begin
                v = (state_q[s] == ST_FRESH) ? i_rf_rd_data[pmap_q[s][j]] : held_q[s][j];
                for (int w = WBPORT_NUM - 1; w >= 0; w--) begin
                    if (i_wb_vld[w] && (i_wb_rdIdx[w] == info_q[s].iprs_idx[j])) begin
                        v = i_wb_data[w];
                    end
                end
                if (info_q[s].iprs_idx[j] == '0) begin
                    v = '0;
                end
                o_fu_srcdata[s][j] = v;
            end
        end
    end

    // Per-slot EMPTY/FRESH/HELD state machine with capture of granted uops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < INOUTPORT_NUM; s++) begin
                state_q[s] <= ST_EMPTY;
            end
        end else begin
            for (int s = 0; s < INOUTPORT_NUM; s++) begin
                if (grant[s]) begin
                    // Grant implies no stall, so this slot is empty or leaving now.
                    state_q[s] <= ST_FRESH;
                    info_q[s]  <= i_issue_exeInfo[s];
                    for (int j = 0; j < NUMSRCS_INT; j++) begin
                        pmap_q[s][j] <= pmap_d[s][j];
                    end
                end else begin
                    case (state_q[s])
                        ST_FRESH: begin
                            if (i_fu_ready[s]) begin
                                state_q[s] <= ST_EMPTY;
                            end else begin
                                // Regfile data is only valid this cycle; keep the resolved value.
                                state_q[s] <= ST_HELD;
                                for (int j = 0; j < NUMSRCS_INT; j++) begin
                                    held_q[s][j] <= o_fu_srcdata[s][j];
                                end
                            end
                        end
                        ST_HELD: begin
                            if (i_fu_ready[s]) begin
                                state_q[s] <= ST_EMPTY;
                            end
                        end
                        default: begin
                            state_q[s] <= ST_EMPTY;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_rfread_stage.sv
// Directed bench for issue_rfread_stage: port allocation, feedback, staging, stall, bypass, reset.
// Inputs driven on the falling edge, outputs sampled 1ns later.
// A small regfile model returns 0x1000+idx one cycle after a read, garbage when not read.

module tb_issue_rfread_stage;
    import issue_rfread_pkg::*;

    localparam int DEPTH = 8;
    localparam int N     = 2;
    localparam int RP    = 3;
    localparam int WB    = 6;
    localparam int IDXW  = $clog2(DEPTH);

    logic                                    clk = 1'b0;
    logic                                    rst;
    logic [N-1:0]                            i_can_issue;
    logic [N-1:0][IDXW-1:0]                  i_issue_idx;
    exeInfo_t [N-1:0]                        i_issue_exeInfo;
    logic                                    o_stall;
    logic [N-1:0]                            o_issue_finished_vec;
    logic [N-1:0]                            o_issue_replay_vec;
    logic [N-1:0][IDXW-1:0]                  o_feedback_idx;
    logic [RP-1:0]                           o_rf_rd_en;
    iprIdx_t [RP-1:0]                        o_rf_rd_idx;
    logic [RP-1:0][XLEN-1:0]                 i_rf_rd_data;
    logic [WB-1:0]                           i_wb_vld;
    iprIdx_t [WB-1:0]                        i_wb_rdIdx;
    logic [WB-1:0][XLEN-1:0]                 i_wb_data;
    logic [N-1:0]                            o_fu_vld;
    exeInfo_t [N-1:0]                        o_fu_exeInfo;
    logic [N-1:0][NUMSRCS_INT-1:0][XLEN-1:0] o_fu_srcdata;
    logic [N-1:0]                            i_fu_ready;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] prev_a;
    logic [31:0] prev_c;

    always #5 clk = ~clk;

    issue_rfread_stage #(
        .DEPTH(DEPTH), .INOUTPORT_NUM(N), .RFREAD_PORTS(RP), .WBPORT_NUM(WB)
    ) dut (
        .clk(clk), .rst(rst),
        .i_can_issue(i_can_issue), .i_issue_idx(i_issue_idx), .i_issue_exeInfo(i_issue_exeInfo),
        .o_stall(o_stall), .o_issue_finished_vec(o_issue_finished_vec),
        .o_issue_replay_vec(o_issue_replay_vec), .o_feedback_idx(o_feedback_idx),
        .o_rf_rd_en(o_rf_rd_en), .o_rf_rd_idx(o_rf_rd_idx), .i_rf_rd_data(i_rf_rd_data),
        .i_wb_vld(i_wb_vld), .i_wb_rdIdx(i_wb_rdIdx), .i_wb_data(i_wb_data),
        .o_fu_vld(o_fu_vld), .o_fu_exeInfo(o_fu_exeInfo), .o_fu_srcdata(o_fu_srcdata),
        .i_fu_ready(i_fu_ready)
    );

    // Regfile model: synchronous read, data valid the cycle after the enable.
    always @(posedge clk) begin
        for (int p = 0; p < RP; p++) begin
            i_rf_rd_data[p] <= o_rf_rd_en[p] ? (32'h1000 + 32'(o_rf_rd_idx[p]))
                                             : (32'hBAD0_0000 + 32'(p));
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_slot(input int s, input logic [IDXW-1:0] idx, input iprIdx_t a, input iprIdx_t b);
        i_issue_idx[s]                 = idx;
        i_issue_exeInfo[s].iprs_idx[0] = a;
        i_issue_exeInfo[s].iprs_idx[1] = b;
        i_issue_exeInfo[s].iprd_idx    = iprIdx_t'(s + 10);
        i_issue_exeInfo[s].rd_wen      = 1'b1;
    endtask

    task automatic clear_wb();
        i_wb_vld   = '0;
        i_wb_rdIdx = '0;
        i_wb_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        i_can_issue = '0;
        i_fu_ready  = '1;
        i_issue_idx = '0;
        i_issue_exeInfo = '0;
        clear_wb();
        repeat (2) @(negedge clk);
        #1;
        check("rst_fu_vld", 64'(o_fu_vld), 64'h0);
        check("rst_stall", 64'(o_stall), 64'h0);
        check("rst_rd_en", 64'(o_rf_rd_en), 64'h0);
        check("rst_fin", 64'(o_issue_finished_vec), 64'h0);
        check("rst_rep", 64'(o_issue_replay_vec), 64'h0);

        // 1: both slots fit in three ports
        @(negedge clk);
        rst = 1'b0;
        set_slot(0, 3'd1, 6'd3, 6'd5);
        set_slot(1, 3'd2, 6'd7, 6'd0);
        i_can_issue = 2'b11;
        #1;
        check("t1_fin", 64'(o_issue_finished_vec), 64'h3);
        check("t1_rep", 64'(o_issue_replay_vec), 64'h0);
        check("t1_rd_en", 64'(o_rf_rd_en), 64'h7);
        check("t1_rd_idx0", 64'(o_rf_rd_idx[0]), 64'd3);
        check("t1_rd_idx1", 64'(o_rf_rd_idx[1]), 64'd5);
        check("t1_rd_idx2", 64'(o_rf_rd_idx[2]), 64'd7);
        @(negedge clk);
        i_can_issue = 2'b00;
        #1;
        check("t1_fu_vld", 64'(o_fu_vld), 64'h3);
        check("t1_s0s0", 64'(o_fu_srcdata[0][0]), 64'h1003);
        check("t1_s0s1", 64'(o_fu_srcdata[0][1]), 64'h1005);
        check("t1_s1s0", 64'(o_fu_srcdata[1][0]), 64'h1007);
        check("t1_s1s1", 64'(o_fu_srcdata[1][1]), 64'h0);
        check("t1_s1_rd", 64'(o_fu_exeInfo[1].iprd_idx), 64'd11);
        check("t1_stall", 64'(o_stall), 64'h0);

        // 2: four sources, three ports -> slot1 replays
        @(negedge clk);
        set_slot(0, 3'd3, 6'd2, 6'd4);
        set_slot(1, 3'd5, 6'd6, 6'd9);
        i_can_issue = 2'b11;
        #1;
        check("t2_fin", 64'(o_issue_finished_vec), 64'h1);
        check("t2_rep", 64'(o_issue_replay_vec), 64'h2);
        check("t2_fb0", 64'(o_feedback_idx[0]), 64'd3);
        check("t2_fb1", 64'(o_feedback_idx[1]), 64'd5);
        check("t2_rd_en", 64'(o_rf_rd_en), 64'h3);
        @(negedge clk);
        i_can_issue = 2'b00;
        #1;
        check("t2_fu_vld", 64'(o_fu_vld), 64'h1);
        check("t2_s0s0", 64'(o_fu_srcdata[0][0]), 64'h1002);
        check("t2_s0s1", 64'(o_fu_srcdata[0][1]), 64'h1004);

        // 3: FU not ready -> stall, held data stable while regfile returns garbage
        @(negedge clk);
        set_slot(0, 3'd1, 6'd1, 6'd2);
        i_can_issue = 2'b01;
        #1;
        check("t3_fin", 64'(o_issue_finished_vec), 64'h1);
        i_fu_ready = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("t3_stall", 64'(o_stall), 64'h1);
            check("t3_fin_stall", 64'(o_issue_finished_vec), 64'h0);
            check("t3_rep_stall", 64'(o_issue_replay_vec), 64'h0);
            check("t3_rd_en_stall", 64'(o_rf_rd_en), 64'h0);
            check("t3_s0s0", 64'(o_fu_srcdata[0][0]), 64'h1001);
            check("t3_s0s1", 64'(o_fu_srcdata[0][1]), 64'h1002);
        end
        @(negedge clk);
        i_fu_ready  = 2'b11;
        i_can_issue = 2'b00;
        #1;
        check("t3_release_stall", 64'(o_stall), 64'h0);
        @(negedge clk);
        #1;
        check("t3_after_vld", 64'(o_fu_vld), 64'h0);
        check("t3_after_stall", 64'(o_stall), 64'h0);

        // 4: bypass overrides stale regfile data, lowest wb port wins, then held
        @(negedge clk);
        set_slot(0, 3'd2, 6'd5, 6'd6);
        i_can_issue = 2'b01;
        #1;
        check("t4_fin", 64'(o_issue_finished_vec), 64'h1);
        @(negedge clk);
        i_can_issue   = 2'b00;
        i_fu_ready    = 2'b10;
        i_wb_vld[2]   = 1'b1;
        i_wb_rdIdx[2] = 6'd5;
        i_wb_data[2]  = 32'hDEAD;
        i_wb_vld[4]   = 1'b1;
        i_wb_rdIdx[4] = 6'd5;
        i_wb_data[4]  = 32'hBEEF;
        #1;
        check("t4_fresh_s0", 64'(o_fu_srcdata[0][0]), 64'hDEAD);
        check("t4_fresh_s1", 64'(o_fu_srcdata[0][1]), 64'h1006);
        @(negedge clk);
        clear_wb();
        #1;
        check("t4_held_s0", 64'(o_fu_srcdata[0][0]), 64'hDEAD);
        check("t4_held_s1", 64'(o_fu_srcdata[0][1]), 64'h1006);
        check("t4_held_stall", 64'(o_stall), 64'h1);
        @(negedge clk);
        i_fu_ready = 2'b11;

        // 5: no valid slots -> no activity; reset while held discards the uop
        @(negedge clk);
        set_slot(0, 3'd1, 6'd8, 6'd9);
        set_slot(1, 3'd2, 6'd10, 6'd11);
        i_can_issue = 2'b00;
        #1;
        check("t5_idle_rd_en", 64'(o_rf_rd_en), 64'h0);
        check("t5_idle_fin", 64'(o_issue_finished_vec), 64'h0);
        check("t5_idle_rep", 64'(o_issue_replay_vec), 64'h0);
        @(negedge clk);
        i_can_issue = 2'b01;
        #1;
        check("t5_fin", 64'(o_issue_finished_vec), 64'h1);
        @(negedge clk);
        i_can_issue = 2'b00;
        i_fu_ready  = 2'b10;
        @(negedge clk);
        #1;
        check("t5_held_vld", 64'(o_fu_vld), 64'h1);
        check("t5_held_stall", 64'(o_stall), 64'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rst_vld", 64'(o_fu_vld), 64'h0);
        check("t5_rst_stall", 64'(o_stall), 64'h0);
        i_fu_ready = 2'b11;

        // 6: back-to-back grants with ready FUs, no bubbles
        prev_a = '0;
        prev_c = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_slot(0, 3'(k), 6'(k + 1), 6'd0);
            set_slot(1, 3'(k + 1), 6'(k + 20), 6'(k + 30));
            i_can_issue = 2'b11;
            #1;
            check("t6_fin", 64'(o_issue_finished_vec), 64'h3);
            check("t6_rd_en", 64'(o_rf_rd_en), 64'h7);
            if (k > 0) begin
                check("t6_fu_vld", 64'(o_fu_vld), 64'h3);
                check("t6_s0s0", 64'(o_fu_srcdata[0][0]), 64'(32'h1000 + prev_a));
                check("t6_s1s1", 64'(o_fu_srcdata[1][1]), 64'(32'h1000 + prev_c));
            end
            prev_a = 32'(k + 1);
            prev_c = 32'(k + 30);
        end
        @(negedge clk);
        i_can_issue = 2'b00;
        #1;
        check("t6_last_vld", 64'(o_fu_vld), 64'h3);
        check("t6_last_s0s0", 64'(o_fu_srcdata[0][0]), 64'(32'h1000 + prev_a));
        check("t6_last_s1s1", 64'(o_fu_srcdata[1][1]), 64'(32'h1000 + prev_c));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
